// File: rtl/dmem_pkg.sv
// Shared types and lane helpers for the byte-lane data memory.
// No state: access-size encoding, FSM states, alignment and lane-mask functions.
package dmem_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } size_t;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  // The unused size encoding is treated as an erroring access.
  function automatic logic misaligned(size_t size, logic [1:0] lane);
    case (size)
      BYTE:    return 1'b0;
      HALF:    return lane[0];
      WORD:    return lane != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(size_t size, logic [1:0] lane);
    case (size)
      BYTE:    return 4'b0001 << lane;
      HALF:    return 4'b0011 << lane;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_bus_if.sv
// Clock and synchronous active-high reset bundle shared by the memory slice.
// The central modport is the consumer side: both signals are inputs.
interface ctrl_bus_if;
  logic clk;
  logic reset;

  modport central (
    input clk,
    input reset
  );
endinterface

// File: rtl/dmem_load_align.sv
// Combinational load lane select and sign/zero extension; zero latency.
// No flow control: result follows the inputs.
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  size_t       size,
  input  logic        uns,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = word[{lane, 3'b000} +: 8];
  // Halves are always aligned, so only the upper lane bit picks the half.
  assign half_sel = word[{lane[1], 4'b0000} +: 16];

  always_comb begin
    result = word;
    case (size)
      BYTE:    result = {{24{~uns & byte_sel[7]}}, byte_sel};
      HALF:    result = {{16{~uns & half_sel[15]}}, half_sel};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/dmem_bytelane.sv
// Byte-lane data memory, one request per cycle, response one cycle after accept.
// Ready is low while clearing after reset; responses cannot be backpressured.
module dmem_bytelane
  import dmem_pkg::*;
#(
  parameter int WORDS      = 64,
  parameter bit INIT_CLEAR = 1'b1
) (
  ctrl_bus_if.central ctrl_bus,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(WORDS);
  localparam logic [AW-1:0] LAST_IDX = AW'(WORDS - 1);

  logic clk;
  logic reset;
  assign clk   = ctrl_bus.clk;
  assign reset = ctrl_bus.reset;

  state_t        state;
  logic [AW-1:0] clr_cnt;
  logic [31:0]   mem [WORDS];

  size_t         size;
  logic [1:0]    lane;
  logic [AW-1:0] idx;
  logic          oob;
  logic          err;
  logic          accept;
  logic          st_we;
  logic          ld_en;
  logic          clr_we;
  logic [3:0]    wmask;
  logic [31:0]   wbytes;

  logic          ld_q;
  logic [1:0]    lane_q;
  size_t         size_q;
  logic          uns_q;
  logic [31:0]   rd_word;
  logic [31:0]   aligned;

  assign size   = size_t'(req_size);
  assign lane   = req_addr[1:0];
  assign idx    = req_addr[AW+1:2];
  assign oob    = |req_addr[31:AW+2];
  assign err    = misaligned(size, lane) || oob;
  assign accept = req_valid && req_ready;
  assign st_we  = accept && req_write && !err;
  assign ld_en  = accept && !req_write && !err;
  assign clr_we = (state == INIT) && !reset;
  assign wmask  = lane_mask(size, lane);

  assign req_ready = (state == RUN) && !reset;

  // Replicate right-aligned store data onto every lane; the mask picks the live ones.
  always_comb begin
    wbytes = req_wdata;
    case (size)
      BYTE:    wbytes = {4{req_wdata[7:0]}};
      HALF:    wbytes = {2{req_wdata[15:0]}};
      default: wbytes = req_wdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= INIT_CLEAR ? INIT : RUN;
      clr_cnt   <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      ld_q      <= 1'b0;
      lane_q    <= 2'b00;
      size_q    <= BYTE;
      uns_q     <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          if (clr_cnt == LAST_IDX) state <= RUN;
          else clr_cnt <= clr_cnt + 1'b1;
        end
        default: state <= RUN;
      endcase
      rsp_valid <= accept;
      rsp_err   <= accept && err;
      ld_q      <= ld_en;
      if (accept) begin
        lane_q <= lane;
        size_q <= size;
        uns_q  <= req_unsigned;
      end
    end
  end

  // Array has no reset; clearing and stores never overlap since ready is low in INIT.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_cnt] <= '0;
    end else if (st_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wmask[b]) mem[idx][8*b +: 8] <= wbytes[8*b +: 8];
      end
    end
    if (ld_en) rd_word <= mem[idx];
  end

  dmem_load_align u_align (
    .word   (rd_word),
    .lane   (lane_q),
    .size   (size_q),
    .uns    (uns_q),
    .result (aligned)
  );

  assign rsp_rdata = ld_q ? aligned : 32'h0;

endmodule

// File: doc/dmem_bytelane.md
DMEM_BYTELANE -- requirements
Module: dmem_bytelane

Interface
REQ-001 SHALL have parameter WORDS, default 64, meaning the number of 32-bit words stored (power of two, 4..4096).
REQ-002 SHALL have parameter INIT_CLEAR, default 1, meaning the array is zeroed after reset.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have port ctrl_bus.clk, input, 1 bit, the clock, via ctrl_bus_if.central.
REQ-005 SHALL have port ctrl_bus.reset, input, 1 bit, the synchronous active-high reset, via ctrl_bus_if.central.
REQ-006 SHALL have port req_valid, input, 1 bit, meaning a request is present.
REQ-007 SHALL have port req_ready, output, 1 bit, meaning a request can be accepted.
REQ-008 SHALL have port req_write, input, 1 bit, meaning 1=store and 0=load.
REQ-009 SHALL have port req_size, input, 2 bits, meaning access size (dmem_pkg::size_t: BYTE, HALF, WORD).
REQ-010 SHALL have port req_unsigned, input, 1 bit, meaning zero-extend loads when 1 and sign-extend when 0.
REQ-011 SHALL have port req_addr, input, 32 bits, meaning the byte address.
REQ-012 SHALL have port req_wdata, input, 32 bits, meaning store data, right-aligned.
REQ-013 SHALL have port rsp_valid, output, 1 bit, meaning a response is present (one-cycle pulse).
REQ-014 SHALL have port rsp_rdata, output, 32 bits, meaning load data after extension.
REQ-015 SHALL have port rsp_err, output, 1 bit, meaning the access was misaligned or out of range.

Function
REQ-016 SHALL accept a request on a rising edge where req_valid && req_ready.
REQ-017 SHALL be controlled by an FSM with states INIT and RUN.
- INIT: clear counter walks 0..WORDS-1, writing zero, one word per cycle; req_ready=0. At WORDS-1 the FSM enters RUN.
- RUN: req_ready=1 every cycle; the FSM never leaves RUN except on reset.
REQ-018 SHALL enter RUN directly from reset when INIT_CLEAR=0.
REQ-019 SHALL compute the word index as req_addr[31:2], with byte lane req_addr[1:0].
REQ-020 SHALL flag an error when:
- HALF has addr[0]=1, or WORD has addr[1:0]!=0 (misaligned); or
- word index >= WORDS (out of range).
REQ-021 SHALL, for an accepted store without error, update only the addressed lanes at the accept edge:
- BYTE: lane = wdata[7:0].
- HALF: lanes {a+1,a} = wdata[15:0].
- WORD: all four lanes.
REQ-022 SHALL leave memory unchanged for an erroring store.
REQ-023 SHALL sample the addressed word at the accept edge for an accepted load, then shift by lane and extend per req_size/req_unsigned.
REQ-024 SHALL assert rsp_valid exactly one cycle after every accepted request (load or store), giving load latency 1 and full back-to-back throughput.
REQ-025 SHALL drive rsp_rdata=0 for stores and erroring loads.
REQ-026 SHALL assert rsp_err with that response when the request erred.
REQ-027 SHALL return the newly written value to a load accepted the cycle after a store to the same word; no bypass is needed because the write commits at the earlier edge.
REQ-028 SHALL not provide response backpressure; the consumer always takes rsp_valid.

Reset
REQ-029 SHALL, while reset is high, drive rsp_valid=0, rsp_err=0, rsp_rdata=0 and the clear counter to 0.
REQ-030 SHALL set the state to INIT (or RUN if INIT_CLEAR=0) while reset is high.
REQ-031 SHALL hold req_ready=0 during reset.
REQ-032 SHALL drop a request in flight at reset: no rsp_valid after reset deassertion for requests accepted before it.
REQ-033 SHALL restart clearing from word 0 on reset during INIT.
REQ-034 SHALL not reset the array contents other than through INIT.

Structure
REQ-035 SHALL take size_t (BYTE=0, HALF=1, WORD=2) and state_t from shared package dmem_pkg.
REQ-036 SHALL place load lane selection and extension in the combinational sub-module dmem_load_align (word, lane, size, unsigned -> 32-bit result).

Verification
REQ-037 SHALL check: reset, WORDS=64 -> req_ready low for 64 cycles, then high; every word loaded reads 0.
REQ-038 SHALL check: WORD store 0xDEADBEEF @0x10, then BYTE store 0x55 @0x11 -> WORD load @0x10 returns 0xDEAD55EF, rsp_err=0.
REQ-039 SHALL check: signed BYTE load @0x13 of 0xDE -> 0xFFFFFFDE; unsigned -> 0x000000DE; signed HALF @0x12 -> 0xFFFFDEAD.
REQ-040 SHALL check: WORD load @0x12 and HALF store @0x21 -> rsp_err=1 and rsp_rdata=0, and memory is unchanged.
REQ-041 SHALL check: store @0x100 with WORDS=64 -> rsp_err=1 and no aliasing write to word 0.
REQ-042 SHALL check: back-to-back store 0x12345678 @0x8 then load @0x8 -> rsp_valid on two consecutive cycles, load returns 0x12345678; reset mid-stream -> no stray rsp_valid.
